// File: rtl/ptp_pkg.sv
// Purpose : shared constants, FSM state type and frame layout for the PTP Sync GMII transmitter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package ptp_pkg;

    localparam logic [15:0] PTP_ETHERTYPE = 16'h88F7;
    localparam logic [47:0] PTP_MCAST_DA  = 48'h011B19000000;
    localparam logic [3:0]  PTP_MSG_SYNC  = 4'h0;
    localparam logic [7:0]  PTP_VERSION   = 8'h02;
    localparam logic [15:0] PTP_SYNC_LEN  = 16'd44;

    // Normal (MSB-first) form of the IEEE 802.3 polynomial; the serialiser
    // runs the reflected form, derived from this with bit_rev32().
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    // Remainder left after running data plus its own FCS (normal form).
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    localparam int PRE_BYTES  = 7;
    localparam int BODY_BYTES = 60;
    localparam int FCS_BYTES  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_BODY,
        ST_FCS,
        ST_IFG
    } tx_state_t;

    // The 60 bytes between SFD and FCS, first transmitted byte in the MSBs.
    typedef struct packed {
        logic [47:0] da;
        logic [47:0] sa;
        logic [15:0] ethertype;
        logic [3:0]  transport;
        logic [3:0]  msg_type;
        logic [7:0]  version;
        logic [15:0] msg_len;
        logic [7:0]  domain;
        logic [7:0]  rsvd0;
        logic [15:0] flags;
        logic [63:0] correction;
        logic [31:0] rsvd1;
        logic [63:0] clock_id;
        logic [15:0] port_num;
        logic [15:0] seq_id;
        logic [7:0]  control;
        logic [7:0]  log_interval;
        logic [47:0] ts_sec;
        logic [31:0] ts_ns;
        logic [15:0] pad;
    } sync_frame_t;

    // Same bits viewed as bytes; index 59 is the first byte on the wire.
    typedef logic [BODY_BYTES-1:0][7:0] frame_bytes_t;

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Purpose : combinational CRC-32 (IEEE 802.3, reflected) advance by one data byte.
// Latency : 0 cycles, purely combinational; the caller owns the CRC register.
// Backpressure: none; caller decides when to load the result.
//
// Ports: crc_cur  current CRC register (reflected, not inverted)
//        data     byte to fold in, bit 0 first as on the wire
//        crc_nxt  CRC register after the byte
module crc32_d8
    import ptp_pkg::*;
(
    input  logic [31:0] crc_cur,
    input  logic [7:0]  data,
    output logic [31:0] crc_nxt
);

    localparam logic [31:0] POLY_REFL = bit_rev32(CRC32_POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_cur;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_nxt = c;
    end

endmodule

// File: rtl/ptp_gmii_tx.sv
// Purpose : emits one-step PTPv2 Sync frames (L2, 0x88F7) on an 8-bit GMII transmit port.
// Latency : TX_EN rises 1 cycle after an accepted start; 72 frame cycles, then IFG_CYCLES idle.
// Backpressure: none; start is dropped while busy=1, there is no queue.
//
// Ports: clk/rst            GMII TX clock, async active-low reset
//        start/seq_id       one-cycle request, sequenceId sampled with it
//        rtc_time_in        {sec[47:0], ns[31:0]}, sampled during the SFD cycle
//        gmii_ctrl/data     TX_EN/TXD, registered
//        busy/done          frame in progress (incl. IFG) / pulse after last FCS byte
module ptp_gmii_tx
    import ptp_pkg::*;
#(
    parameter logic [47:0] SRC_MAC      = 48'h000A35000001,
    parameter logic [7:0]  DOMAIN       = 8'd0,
    parameter logic [7:0]  LOG_INTERVAL = 8'h00,
    parameter int          IFG_CYCLES   = 12     // must be >= 1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] seq_id,
    input  logic [79:0] rtc_time_in,
    output logic        gmii_ctrl,
    output logic [7:0]  gmii_data,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] PRE_LAST  = 16'(PRE_BYTES - 1);
    localparam logic [15:0] BODY_LAST = 16'(BODY_BYTES - 1);
    localparam logic [15:0] FCS_LAST  = 16'(FCS_BYTES - 1);
    localparam logic [15:0] IFG_LAST  = 16'(IFG_CYCLES - 1);

    tx_state_t    state, state_nxt;
    logic [15:0]  cnt, cnt_nxt;
    logic [15:0]  seq_q;
    logic [79:0]  ts_q;
    logic [31:0]  crc_q, crc_upd, crc_d, crc_fin;

    logic         ctrl_d, busy_d, done_d;
    logic [7:0]   data_d;

    sync_frame_t  frame;
    frame_bytes_t frame_bytes;
    logic [5:0]   body_idx;

    // Frame contents; only seq_q and ts_q vary between frames.
    always_comb begin
        frame              = '0;
        frame.da           = PTP_MCAST_DA;
        frame.sa           = SRC_MAC;
        frame.ethertype    = PTP_ETHERTYPE;
        frame.transport    = 4'h0;
        frame.msg_type     = PTP_MSG_SYNC;
        frame.version      = PTP_VERSION;
        frame.msg_len      = PTP_SYNC_LEN;
        frame.domain       = DOMAIN;
        frame.clock_id     = {SRC_MAC[47:24], 16'hFFFE, SRC_MAC[23:0]};
        frame.port_num     = 16'h0001;
        frame.seq_id       = seq_q;
        frame.log_interval = LOG_INTERVAL;
        frame.ts_sec       = ts_q[79:32];
        frame.ts_ns        = ts_q[31:0];
    end

    assign frame_bytes = frame;

    // State register; outputs are registered from the next-state decode so
    // every GMII output comes straight off a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            seq_q     <= '0;
            ts_q      <= '0;
            crc_q     <= CRC32_INIT;
            gmii_ctrl <= 1'b0;
            gmii_data <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            crc_q     <= crc_d;
            gmii_ctrl <= ctrl_d;
            gmii_data <= data_d;
            busy      <= busy_d;
            done      <= done_d;
            if (state == ST_IDLE && start) begin
                seq_q <= seq_id;
            end
            // Timestamp is frozen on the SFD cycle so the value on the wire
            // matches the moment the frame's start delimiter went out.
            if (state == ST_SFD) begin
                ts_q <= rtc_time_in;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 16'd1;
        unique case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (start) begin
                    state_nxt = ST_PRE;
                end
            end
            ST_PRE: begin
                if (cnt == PRE_LAST) begin
                    state_nxt = ST_SFD;
                    cnt_nxt   = '0;
                end
            end
            ST_SFD: begin
                state_nxt = ST_BODY;
                cnt_nxt   = '0;
            end
            ST_BODY: begin
                if (cnt == BODY_LAST) begin
                    state_nxt = ST_FCS;
                    cnt_nxt   = '0;
                end
            end
            ST_FCS: begin
                if (cnt == FCS_LAST) begin
                    state_nxt = ST_IFG;
                    cnt_nxt   = '0;
                end
            end
            ST_IFG: begin
                if (cnt == IFG_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: values for the cycle after this edge.
    assign body_idx = 6'(BODY_LAST) - cnt_nxt[5:0];
    assign crc_fin  = ~crc_q;

    // The CRC absorbs the very byte being loaded into gmii_data, so after
    // the last body byte is loaded crc_q already covers the whole frame.
    crc32_d8 u_crc (
        .crc_cur (crc_q),
        .data    (data_d),
        .crc_nxt (crc_upd)
    );

    always_comb begin
        ctrl_d = 1'b0;
        data_d = 8'h00;
        busy_d = (state_nxt != ST_IDLE);
        done_d = (state == ST_FCS) && (state_nxt == ST_IFG);
        crc_d  = CRC32_INIT;
        unique case (state_nxt)
            ST_PRE: begin
                ctrl_d = 1'b1;
                data_d = 8'h55;
            end
            ST_SFD: begin
                ctrl_d = 1'b1;
                data_d = 8'hD5;
            end
            ST_BODY: begin
                ctrl_d = 1'b1;
                data_d = frame_bytes[body_idx];
                crc_d  = crc_upd;
            end
            ST_FCS: begin
                // Least significant CRC byte goes first (802.3 bit order).
                ctrl_d = 1'b1;
                data_d = crc_fin[{cnt_nxt[1:0], 3'b000} +: 8];
                crc_d  = crc_q;
            end
            default: begin
                ctrl_d = 1'b0;
                data_d = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_ptp_gmii_tx.sv
module tb_ptp_gmii_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_m, start_o;
    logic [15:0] seq_id;
    logic [79:0] rtc;
    logic        ctrl_m, ctrl_o, busy_m, busy_o, done_m, done_o;
    logic [7:0]  data_m, data_o;

    always #5 clk = ~clk;

    ptp_gmii_tx dut_m (
        .clk         (clk),
        .rst         (rst),
        .start       (start_m),
        .seq_id      (seq_id),
        .rtc_time_in (rtc),
        .gmii_ctrl   (ctrl_m),
        .gmii_data   (data_m),
        .busy        (busy_m),
        .done        (done_m)
    );

    ptp_gmii_tx #(
        .SRC_MAC (48'hAABBCCDDEEFF),
        .DOMAIN  (8'h05)
    ) dut_o (
        .clk         (clk),
        .rst         (rst),
        .start       (start_o),
        .seq_id      (seq_id),
        .rtc_time_in (rtc),
        .gmii_ctrl   (ctrl_o),
        .gmii_data   (data_o),
        .busy        (busy_o),
        .done        (done_o)
    );

    int          n_vec = 0;
    int          n_bad = 0;

    logic        cap_ctrl [0:255];
    logic [7:0]  cap_data [0:255];
    logic        cap_busy [0:255];
    logic        cap_done [0:255];
    logic [7:0]  exp_body [0:59];

    int          st_cyc [0:3];
    logic [15:0] st_sid [0:3];
    int          n_st;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Textbook MSB-first CRC-32; wire bit order handled by reversing each byte.
    function automatic logic [31:0] crc_msb(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {rev8(b), 24'h000000};
        for (int i = 0; i < 8; i++) begin
            if (x[31]) x = (x << 1) ^ 32'h04C11DB7;
            else       x = x << 1;
        end
        return x;
    endfunction

    task automatic build_expected(input logic [47:0] mac, input logic [7:0] dom,
                                  input logic [15:0] sid, input logic [47:0] sec,
                                  input logic [31:0] ns);
        logic [47:0] da;
        da = 48'h011B19000000;
        for (int i = 0; i < 60; i++) exp_body[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            exp_body[i]      = da[47-8*i -: 8];
            exp_body[6+i]    = mac[47-8*i -: 8];
            exp_body[48+i]   = sec[47-8*i -: 8];
        end
        exp_body[12] = 8'h88;
        exp_body[13] = 8'hF7;
        exp_body[15] = 8'h02;
        exp_body[17] = 8'h2C;
        exp_body[18] = dom;
        for (int i = 0; i < 3; i++) begin
            exp_body[34+i] = mac[47-8*i -: 8];
            exp_body[39+i] = mac[23-8*i -: 8];
        end
        exp_body[37] = 8'hFF;
        exp_body[38] = 8'hFE;
        exp_body[43] = 8'h01;
        exp_body[44] = sid[15:8];
        exp_body[45] = sid[7:0];
        for (int i = 0; i < 4; i++) exp_body[54+i] = ns[31-8*i -: 8];
    endtask

    // Call right after a negedge: that negedge is cycle 0. Samples cycles 1..ncyc.
    task automatic capture(input bit ov, input int ncyc, input bit rtc_inc);
        for (int c = 0; c <= ncyc; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (rtc_inc) rtc = rtc + 80'd1;
                cap_ctrl[c] = ov ? ctrl_o : ctrl_m;
                cap_data[c] = ov ? data_o : data_m;
                cap_busy[c] = ov ? busy_o : busy_m;
                cap_done[c] = ov ? done_o : done_m;
            end
            start_m = 1'b0;
            start_o = 1'b0;
            for (int k = 0; k < n_st; k++) begin
                if (st_cyc[k] == c) begin
                    seq_id = st_sid[k];
                    if (ov) start_o = 1'b1;
                    else    start_m = 1'b1;
                end
            end
        end
        start_m = 1'b0;
        start_o = 1'b0;
    endtask

    // Check one frame whose start was accepted in captured cycle b.
    task automatic check_frame(input int b, input string nm);
        int          n;
        logic [31:0] m;
        logic [31:0] fcs;
        n = 0;
        for (int c = 1; c <= 7; c++) if (cap_ctrl[b+c] && cap_data[b+c] == 8'h55) n++;
        check($sformatf("%s.preamble", nm), 80'(n), 80'd7);
        check($sformatf("%s.sfd", nm), 80'({cap_ctrl[b+8], cap_data[b+8]}), 80'h1D5);
        for (int i = 0; i < 60; i++) begin
            check($sformatf("%s.byte%0d", nm, i), 80'({cap_ctrl[b+9+i], cap_data[b+9+i]}),
                  80'({1'b1, exp_body[i]}));
        end
        m = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) m = crc_msb(m, exp_body[i]);
        fcs = ~rev32(m);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s.fcs%0d", nm, k), 80'({cap_ctrl[b+69+k], cap_data[b+69+k]}),
                  80'({1'b1, fcs[8*k +: 8]}));
        end
        m = 32'hFFFFFFFF;
        for (int i = 0; i < 64; i++) m = crc_msb(m, cap_data[b+9+i]);
        check($sformatf("%s.residue", nm), 80'(m), 80'h0C704DD7B);
        n = 0;
        for (int c = 1; c <= 72; c++) if (cap_ctrl[b+c]) n++;
        check($sformatf("%s.txen_cycles", nm), 80'(n), 80'd72);
        check($sformatf("%s.end_cycle", nm), 80'({cap_ctrl[b+73], cap_data[b+73], cap_done[b+73]}),
              80'h001);
        n = 0;
        for (int c = 1; c <= 84; c++) if (cap_done[b+c]) n++;
        check($sformatf("%s.done_pulses", nm), 80'(n), 80'd1);
        n = 0;
        for (int c = 1; c <= 84; c++) if (cap_busy[b+c]) n++;
        check($sformatf("%s.busy_cycles", nm), 80'(n), 80'd84);
        check($sformatf("%s.busy_clear", nm), 80'(cap_busy[b+85]), 80'd0);
        n = 0;
        for (int c = 73; c <= 85; c++) if (cap_busy[b+c] && !cap_ctrl[b+c]) n++;
        check($sformatf("%s.ifg_cycles", nm), 80'(n), 80'd12);
        n = 0;
        for (int c = 73; c <= 85; c++) if (!cap_ctrl[b+c] && cap_data[b+c] != 8'h00) n++;
        check($sformatf("%s.idle_data", nm), 80'(n), 80'd0);
    endtask

    initial begin
        rst     = 1'b0;
        start_m = 1'b0;
        start_o = 1'b0;
        seq_id  = 16'h0000;
        rtc     = '0;
        n_st    = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.main", 80'({ctrl_m, data_m, busy_m, done_m}), 80'd0);
        check("reset.ovr",  80'({ctrl_o, data_o, busy_o, done_o}), 80'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle.main", 80'({ctrl_m, data_m, busy_m, done_m}), 80'd0);

        // Basic frame, starts while busy (40, 84) ignored, start at 85 accepted
        rtc = {48'h5, 32'h3B9AC9FF};
        n_st = 4;
        st_cyc[0] = 0;  st_sid[0] = 16'h1234;
        st_cyc[1] = 40; st_sid[1] = 16'hDEAD;
        st_cyc[2] = 84; st_sid[2] = 16'hBEEF;
        st_cyc[3] = 85; st_sid[3] = 16'h5678;
        capture(1'b0, 175, 1'b0);
        build_expected(48'h000A35000001, 8'h00, 16'h1234, 48'h5, 32'h3B9AC9FF);
        check_frame(0, "basic");
        check("b2b.cycle85_86", 80'({cap_ctrl[85], cap_ctrl[86], cap_data[86]}), 80'h155);
        build_expected(48'h000A35000001, 8'h00, 16'h5678, 48'h5, 32'h3B9AC9FF);
        check_frame(85, "b2b");

        // Timestamp capture point: rtc = base + cycle, so cycle 8 gives base + 8
        rtc = {48'h0000000000AB, 32'h00000010};
        n_st = 1;
        st_cyc[0] = 0; st_sid[0] = 16'h0777;
        capture(1'b0, 90, 1'b1);
        build_expected(48'h000A35000001, 8'h00, 16'h0777, 48'hAB, 32'h18);
        check_frame(0, "tscap");
        check("tscap.value",
              {cap_data[57], cap_data[58], cap_data[59], cap_data[60], cap_data[61],
               cap_data[62], cap_data[63], cap_data[64], cap_data[65], cap_data[66]},
              {48'h0000000000AB, 32'h00000018});

        // Reset in the middle of a frame
        seq_id  = 16'h1111;
        start_m = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start_m = 1'b0;
        end
        check("midrst.before", 80'({ctrl_m, busy_m}), 80'h3);
        rst = 1'b0;
        #1;
        check("midrst.after", 80'({ctrl_m, data_m, busy_m, done_m}), 80'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst.idle", 80'({ctrl_m, busy_m, done_m}), 80'd0);
        rtc = {48'h000012345678, 32'h0ABCDEF0};
        st_cyc[0] = 0; st_sid[0] = 16'hC0DE;
        capture(1'b0, 90, 1'b0);
        build_expected(48'h000A35000001, 8'h00, 16'hC0DE, 48'h000012345678, 32'h0ABCDEF0);
        check_frame(0, "postrst");

        // Parameter override instance
        rtc = {48'h000060000001, 32'h00000100};
        st_cyc[0] = 0; st_sid[0] = 16'h0042;
        capture(1'b1, 90, 1'b0);
        build_expected(48'hAABBCCDDEEFF, 8'h05, 16'h0042, 48'h000060000001, 32'h00000100);
        check_frame(0, "override");
        check("override.main_quiet", 80'({ctrl_m, busy_m}), 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ptp_gmii_tx.md
Name: ptp_gmii_tx

Overview:
- GMII transmit-side generator for one-step PTPv2 Sync frames over Ethernet L2 (ethertype 0x88F7).
- It is the transmitting counterpart of the timestamp unit that parses GMII streams.
- It serialises preamble, SFD, MAC header, PTP header, originTimestamp, pad and CRC-32 FCS onto an 8-bit GMII port.
- Used for loopback test and master-clock emission, with its output feeding tx_gmii_ctrl/tx_gmii_data.

Parameters:
SRC_MAC, 48'h000A35000001, source MAC; also forms clockIdentity
DOMAIN, 8'd0, PTP domainNumber
LOG_INTERVAL, 8'h00, logMessageInterval
IFG_CYCLES, 12, idle cycles enforced after the last FCS byte

Ports:
clk  in  1  GMII transmit clock; the only clock
rst  in  1  reset; asynchronous assert, active-low (0 = reset)
start  in  1  single-cycle request; accepted only when busy=0
seq_id  in  16  sequenceId; sampled with start
rtc_time_in  in  80  {sec[47:0], ns[31:0]}; must already be synchronous to clk
gmii_ctrl  out  1  TX_EN
gmii_data  out  8  TXD
busy  out  1  high from the accepted start until the end of IFG
done  out  1  one-cycle pulse after the last FCS byte

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, counters and CRC cleared. Deassertion is used synchronously.
- FSM states: IDLE -> PRE -> SFD -> BODY -> FCS -> IFG -> IDLE.
- Cycle 0, start=1 in IDLE: latch seq_id, set busy=1 (registered, visible at cycle 1).
- Cycles 1-7, PRE: gmii_ctrl=1, data=0x55.
- Cycle 8, SFD: data=0xD5. rtc_time_in is captured into the timestamp register on this cycle.
- Cycles 9-68, BODY: 60 bytes, byte counter 0..59, MSB-first fields:
  - 0-5: DA 01:1B:19:00:00:00.
  - 6-11: SRC_MAC.
  - 12-13: 88 F7.
  - 14: 0x00 (messageType Sync).
  - 15: 0x02 (version).
  - 16-17: 0x002C (length 44).
  - 18: DOMAIN.
  - 19: 0x00.
  - 20-21: flags 0x0000 (one-step).
  - 22-29: correction 0.
  - 30-33: 0.
  - 34-41: clockIdentity = SRC_MAC[47:24], FF, FE, SRC_MAC[23:0].
  - 42-43: portNumber 0x0001.
  - 44-45: seq_id.
  - 46: 0x00.
  - 47: LOG_INTERVAL.
  - 48-53: sec.
  - 54-57: ns.
  - 58-59: pad 0x00.
- CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) updates on every BODY byte.
- Cycles 69-72, FCS: transmit ~crc, LSB byte first (crc[7:0] first, bit-reflected convention as IEEE 802.3).
- Cycle 73: gmii_ctrl=0, data=0x00, done=1 for one cycle. IFG begins.
- IFG: IFG_CYCLES cycles with gmii_ctrl=0 (cycles 73..84 at default), then IDLE.
- busy=0 from cycle 85; a start at cycle 85 is accepted.
- gmii_data=0x00 whenever gmii_ctrl=0.
- start while busy=1: ignored. No queuing and no effect on the current frame.
- rtc_time_in changes after cycle 8 do not affect the transmitted timestamp.
- Reset mid-frame: the frame is truncated immediately (gmii_ctrl drops asynchronously). There is no done pulse, and busy=0.
- All outputs are registered. Frame length is fixed at 72 GMII cycles (8 preamble/SFD + 64 frame bytes).

Decomposition:
- Shared package ptp_pkg:
  - PTP_ETHERTYPE=16'h88F7
  - PTP_MCAST_DA=48'h011B19000000
  - PTP_MSG_SYNC=4'h0
  - PTP_VERSION=8'h02
  - PTP_SYNC_LEN=16'd44
  - CRC32_POLY
  - CRC32_RESIDUE=32'hC704DD7B
  - FSM state enum
- Sub-module crc32_d8: combinational next-CRC for 8-bit data, with registered state kept in ptp_gmii_tx. It is reusable by a future receive-side FCS checker.

Test Plan:
- Basic frame: rst released, start with seq_id=0x1234, rtc={48'h5, 32'h3B9AC9FF} -> gmii_ctrl high cycles 1-72; data 0x55 x7, 0xD5 at cycle 8; bytes 44-45 = 12 34; bytes 48-57 = 00 00 00 00 00 05 3B 9A C9 FF; done at cycle 73.
- FCS check: the bench reference CRC over bytes 0-63 (FCS included) yields residue 0xC704DD7B; corrupt-model cross-check against an independent byte-wise CRC equals the transmitted FCS.
- Timestamp capture point: rtc_time_in incrementing every cycle -> transmitted sec/ns equal the value present on cycle 8 exactly.
- Start during busy: second start at cycles 40 and 84 -> ignored, single frame. Start at cycle 85 -> new preamble begins at cycle 86. The inter-frame gap is exactly 12 idle cycles.
- Reset mid-frame: rst=0 at cycle 30 -> gmii_ctrl/busy/done=0 within the same cycle. After release, a start produces a complete correct frame with the new seq_id.
- Parameter override: SRC_MAC=48'hAABBCCDDEEFF, DOMAIN=8'h05 -> bytes 6-11 = AA BB CC DD EE FF; bytes 34-41 = AA BB CC FF FE DD EE FF; byte 18 = 05; FCS still valid.
